// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl
//   Byte FIFO plus send sequencer in front of a UART byte transmitter.
//   Producers push bytes with wr_en/wr_data; the sequencer pops one byte at
//   a time, presents it on data_byte with a one-cycle send_en pulse, then
//   waits for Tx_Done before popping the next.
//
// Ports
//   Clk, Rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    producer write strobe and byte
//   full, empty       FIFO status (combinational from the pointers)
//   level             entry count (combinational from the pointers)
//   data_byte         byte presented to the transmitter (registered, held)
//   send_en           one-cycle start pulse to the transmitter
//   Tx_Done           one-cycle completion pulse from the transmitter
//   ovf_clr           clears the sticky overflow flag
//   overflow          sticky flag: a write was dropped because FIFO was full
//
// Build option
//   UART_TX_FIFO_OVF_FLAG_EN  when defined, overflow is a live sticky flag;
//                             otherwise it is tied low and ovf_clr is unused.

module uart_tx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            data_byte,
  output logic                  send_en,
  input  logic                  Tx_Done,
  input  logic                  ovf_clr,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                wr_acc;
  logic                pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign wr_acc = wr_en && !full;

  always_ff @(posedge Clk) begin
    if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (Tx_Done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // send_en is registered from the pop, so it is high exactly while the
  // FSM sits in SEND; data_byte is loaded on the same edge and then held.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_byte <= 8'h00;
      send_en   <= 1'b0;
    end else begin
      send_en <= pop;
      if (pop) data_byte <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)              overflow <= 1'b0;
    else if (wr_en && full)  overflow <= 1'b1;
    else if (ovf_clr)        overflow <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule
